poly_chord_mixer: RTL and testbench
===================================

// Module: poly_chord_mixer
// PURPOSE
//  Parametrised successor to the 3-voice chord player: allocates incoming notes to NUM_VOICES voice slots.
//  Counts each note's duration down in beats, with optional voice stealing when all slots are busy.
//  Mixes the per-voice samples from external voice generators into one 16-bit output per sample request.
//  Sits between the song reader/note decoder and the codec sample interface.
// PARAMETERS
//  NUM_VOICES  4   voice slots, power of 2, 2..16
//  NOTE_W      6   note code width; code 0 = rest
//  DUR_W       6   duration width, in beats
//  SAMPLE_W    16  signed sample width
//  STEAL_EN    1   1: steal a voice when all busy; 0: drop the note
//  MIX_MODE    0   0: sum >>> log2(NUM_VOICES); 1: unscaled sum, saturated to SAMPLE_W
// PORTS
//  clk                   in   1                    system clock, rising edge
//  reset                 in   1                    asynchronous, active-high
//  play                  in   1                    1 = run, 0 = pause
//  note                  in   NOTE_W               note code, valid with new_note
//  duration              in   DUR_W                length in beats, valid with new_note
//  new_note              in   1                    1-cycle note strobe
//  beat                  in   1                    1-cycle beat tick
//  generate_next_sample  in   1                    1-cycle sample request
//  voice_sample          in   NUM_VOICES*SAMPLE_W  signed generator outputs; voice i at [i*SAMPLE_W +: SAMPLE_W]
//  voice_note            out  NUM_VOICES*NOTE_W    note assigned to each voice
//  voice_active          out  NUM_VOICES           voice i is sounding
//  voice_load            out  NUM_VOICES           1-cycle pulse: restart generator i phase
//  sample_out            out  SAMPLE_W             mixed signed sample
//  new_sample_ready      out  1                    1-cycle pulse when sample_out updates
//  note_dropped          out  1                    1-cycle pulse: note discarded, no free voice (STEAL_EN=0)
// BEHAVIOUR
//  Reset (async): all outputs 0, all remaining-beat counters 0, mixer FSM in IDLE.
//  Allocation happens on the cycle where new_note & play & note!=0 & duration!=0; otherwise new_note is ignored.
//   - Target is the lowest-index idle voice.
//   - Registered next edge: voice_note[i]<=note, rem[i]<=duration, voice_active[i]<=1, voice_load[i] pulses 1 cycle.
//  All voices busy:
//   - STEAL_EN=1: steal the voice with the smallest rem; ties go to the lowest index. Reload as above, voice_load pulses.
//   - STEAL_EN=0: no change; note_dropped pulses 1 cycle.
//  Duration countdown: on beat & play, every active voice decrements rem.
//   - A voice whose rem goes 1->0 clears voice_active on the same edge. voice_note holds its last value.
//  Simultaneous new_note & beat: the voice being loaded takes the new duration and does not decrement that cycle.
//   All other voices decrement normally. A voice expiring on this beat counts as busy for allocation.
//  play=0:
//   - rem and voice_active are frozen; new_note and beat are ignored.
//   - Mixer still runs and outputs 0 (contributions forced to 0).
//  Mixer FSM states IDLE -> ACC -> OUT -> IDLE.
//   - IDLE: on generate_next_sample, acc<=0, idx<=0, go to ACC.
//   - ACC: one voice per cycle. acc += sign-extended voice_sample[idx] if voice_active[idx]&play, else +0.
//     idx++; after idx=NUM_VOICES-1 go to OUT.
//   - acc width is SAMPLE_W+log2(NUM_VOICES); it cannot overflow.
//   - OUT: sample_out<=scaled acc (MIX_MODE rule; mode 1 clamps to +/-full scale); new_sample_ready=1 for 1 cycle.
//  Latency: request at edge t -> new_sample_ready high in cycle t+NUM_VOICES+1.
//   voice_sample must be stable from t+1 to t+NUM_VOICES.
//  generate_next_sample while not in IDLE is ignored; no queueing.
//  voice_active changes mid-accumulation are taken as sampled in each voice's own ACC cycle.
//  sample_out holds its value between pulses.
//  Reset mid-operation: immediate return to the reset state; a pending new_sample_ready is not issued.
// TESTING
//  1. Reset, then note=37 dur=4 new_note -> voice0 active, voice_load=0001.
//     After 4 beats voice_active=0000; other voices untouched.
//  2. Notes 37,41,44,49 back-to-back -> voices 0..3 active with those codes.
//     With all voice_sample=+1000, MIX_MODE=0: sample_out=1000 after each request, latency 5 cycles.
//  3. 5th note 52 while 4 busy with rem 4,2,3,2:
//     STEAL_EN=1 -> voice1 reloaded with 52, voice_load=0010.
//     STEAL_EN=0 -> note_dropped pulses, state unchanged.
//  4. new_note coincident with beat -> new voice rem=duration; existing voice rem decremented by 1.
//     note=0 or duration=0 -> ignored.
//  5. MIX_MODE=1, 4 voices at +30000 -> sample_out=32767; at -30000 -> sample_out=-32768.
//  6. play=0 for 3 beats -> rem unchanged and sample_out=0. Assert reset during ACC -> outputs 0, no ready pulse.

Source files
------------

// File: rtl/poly_chord_mixer.sv
// Polyphonic note allocator with beat-driven duration countdown and voice stealing,
// plus a sequential per-voice sample mixer that produces one scaled sample per request.
module poly_chord_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int SAMPLE_W   = 16,
  parameter int STEAL_EN   = 1,
  parameter int MIX_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [NOTE_W-1:0]              note,
  input  logic [DUR_W-1:0]               duration,
  input  logic                           new_note,
  input  logic                           beat,
  input  logic                           generate_next_sample,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic [NUM_VOICES-1:0]          voice_load,
  output logic signed [SAMPLE_W-1:0]     sample_out,
  output logic                           new_sample_ready,
  output logic                           note_dropped
);

  localparam int LOG2V = $clog2(NUM_VOICES);
  localparam int AW    = SAMPLE_W + LOG2V;
  localparam logic [LOG2V-1:0] LAST_IDX = LOG2V'(NUM_VOICES - 1);
  localparam logic signed [AW-1:0] POS_MAX = {{(LOG2V+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] NEG_MIN = {{(LOG2V+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} mix_state_t;

  logic [DUR_W-1:0]           rem      [NUM_VOICES];
  logic [NOTE_W-1:0]          note_reg [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] samples  [NUM_VOICES];
  logic                       note_ok, any_idle, do_load;
  logic [LOG2V-1:0]           free_idx, steal_idx, target_idx;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
    assign voice_note[g*NOTE_W +: NOTE_W] = note_reg[g];
    assign samples[g] = voice_sample[g*SAMPLE_W +: SAMPLE_W];
  end

  // Lowest-index idle voice, and the busy voice closest to finishing (ties to lowest index)
  always_comb begin
    free_idx  = '0;
    steal_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (!voice_active[i]) free_idx = LOG2V'(i);
    for (int i = 1; i < NUM_VOICES; i++)
      if (rem[i] < rem[steal_idx]) steal_idx = LOG2V'(i);
  end

  assign any_idle   = ~&voice_active;
  assign note_ok    = new_note & play & (|note) & (|duration);
  assign do_load    = note_ok & (any_idle | (STEAL_EN != 0));
  assign target_idx = any_idle ? free_idx : steal_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      voice_active <= '0;
      voice_load   <= '0;
      note_dropped <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rem[i]      <= '0;
        note_reg[i] <= '0;
      end
    end else begin
      voice_load   <= '0;
      note_dropped <= note_ok & ~any_idle & (STEAL_EN == 0);
      if (play) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (do_load && target_idx == LOG2V'(i)) begin
            note_reg[i]     <= note;
            rem[i]          <= duration;
            voice_active[i] <= 1'b1;
            voice_load[i]   <= 1'b1;
          end else if (beat && voice_active[i]) begin
            rem[i] <= rem[i] - 1'b1;
            if (rem[i] == DUR_W'(1)) voice_active[i] <= 1'b0;
          end
        end
      end
    end
  end

  mix_state_t             state, next_state;
  logic [LOG2V-1:0]       idx;
  logic signed [AW-1:0]   acc, addend;
  logic signed [SAMPLE_W-1:0] scaled;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (generate_next_sample) next_state = ACC;
      ACC:     if (idx == LAST_IDX) next_state = OUT;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Silent voices and paused playback contribute zero rather than stalling the mixer
  always_comb begin
    addend = '0;
    if (voice_active[idx] && play)
      addend = {{LOG2V{samples[idx][SAMPLE_W-1]}}, samples[idx]};
    scaled = acc[AW-1:LOG2V];
    if (MIX_MODE != 0) begin
      if (acc > POS_MAX)      scaled = POS_MAX[SAMPLE_W-1:0];
      else if (acc < NEG_MIN) scaled = NEG_MIN[SAMPLE_W-1:0];
      else                    scaled = acc[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      acc              <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      state            <= next_state;
      new_sample_ready <= (state == OUT);
      case (state)
        IDLE: if (generate_next_sample) begin
          acc <= '0;
          idx <= '0;
        end
        ACC: begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
        end
        OUT:     sample_out <= scaled;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_chord_mixer.sv
// Scoreboard bench: two instances (steal + averaging mix, drop + saturating mix) share one
// directed stimulus stream; samples are checked by monitors, voice state by direct checks.
module tb_poly_chord_mixer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play = 1'b1;
  logic [5:0] note = '0;
  logic [5:0] duration = '0;
  logic new_note = 1'b0;
  logic beat = 1'b0;
  logic generate_next_sample = 1'b0;
  logic signed [15:0] vs [4];
  logic [63:0] voice_sample;

  logic [23:0] a_vn, b_vn;
  logic [3:0]  a_act, b_act, a_load, b_load;
  logic signed [15:0] a_out, b_out;
  logic a_rdy, b_rdy, a_drop, b_drop;

  assign voice_sample = {vs[3], vs[2], vs[1], vs[0]};

  poly_chord_mixer #(.STEAL_EN(1), .MIX_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
    .new_note(new_note), .beat(beat), .generate_next_sample(generate_next_sample),
    .voice_sample(voice_sample), .voice_note(a_vn), .voice_active(a_act),
    .voice_load(a_load), .sample_out(a_out), .new_sample_ready(a_rdy), .note_dropped(a_drop));

  poly_chord_mixer #(.STEAL_EN(0), .MIX_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
    .new_note(new_note), .beat(beat), .generate_next_sample(generate_next_sample),
    .voice_sample(voice_sample), .voice_note(b_vn), .voice_active(b_act),
    .voice_load(b_load), .sample_out(b_out), .new_sample_ready(b_rdy), .note_dropped(b_drop));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [15:0] val;
    int                 due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors pop one expectation per ready pulse and check value and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    if (a_rdy) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_a_unexpected sample=%0d cycle=%0d expected=none", a_out, cyc);
      end else begin
        e = qa.pop_front();
        if (a_out !== e.val || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL sb_a sample=%0d cycle=%0d expected sample=%0d cycle=%0d",
                   a_out, cyc, e.val, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rdy) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_b_unexpected sample=%0d cycle=%0d expected=none", b_out, cyc);
      end else begin
        e = qb.pop_front();
        if (b_out !== e.val || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL sb_b sample=%0d cycle=%0d expected sample=%0d cycle=%0d",
                   b_out, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic nn, input logic [5:0] n, input logic [5:0] d,
                                input logic bt, input logic gen);
    new_note = nn;
    note = n;
    duration = d;
    beat = bt;
    generate_next_sample = gen;
    @(posedge clk);
    #1;
    new_note = 1'b0;
    beat = 1'b0;
    generate_next_sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_vs(input logic signed [15:0] s0, input logic signed [15:0] s1,
                        input logic signed [15:0] s2, input logic signed [15:0] s3);
    vs[0] = s0;
    vs[1] = s1;
    vs[2] = s2;
    vs[3] = s3;
  endtask

  task automatic request(input logic signed [15:0] ea, input logic signed [15:0] eb);
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    qa.push_back('{ea, cyc + 5});
    qb.push_back('{eb, cyc + 5});
    idle(6);
  endtask

  initial begin
    int pulses;
    set_vs(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    #2 reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_output("reset_active", {a_act, b_act}, 8'h00);
    check_output("reset_sample", {a_out, b_out}, 32'h0);
    check_output("reset_notes", {a_vn, b_vn}, 48'h0);

    // Single note, counted down by beats
    apply_stimulus(1'b1, 6'd37, 6'd4, 1'b0, 1'b0);
    check_output("t1_active", {a_act, b_act}, 8'h11);
    check_output("t1_load", {a_load, b_load}, 8'h11);
    check_output("t1_note0", a_vn[5:0], 6'd37);
    repeat (3) apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t1_load_pulse", a_load, 4'b0000);
    check_output("t1_active_3beats", {a_act, b_act}, 8'h11);
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t1_expired", {a_act, b_act}, 8'h00);
    check_output("t1_note_hold", a_vn, {18'd0, 6'd37});

    // Fill all four voices back to back, then mix equal samples
    apply_stimulus(1'b1, 6'd37, 6'd4, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd41, 6'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd44, 6'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd49, 6'd2, 1'b0, 1'b0);
    check_output("t2_active", {a_act, b_act}, 8'hFF);
    check_output("t2_notes", a_vn, {6'd49, 6'd44, 6'd41, 6'd37});
    set_vs(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
    request(16'sd1000, 16'sd4000);
    request(16'sd1000, 16'sd4000);
    check_output("t2_hold", {a_out, b_out}, {16'sd1000, 16'sd4000});

    // Fifth note with all voices busy: steal the smallest remaining (voice1) or drop
    apply_stimulus(1'b1, 6'd52, 6'd5, 1'b0, 1'b0);
    check_output("t3_steal_load", a_load, 4'b0010);
    check_output("t3_steal_note", a_vn, {6'd49, 6'd44, 6'd52, 6'd37});
    check_output("t3_drop_pulse", {a_drop, b_drop}, 2'b01);
    check_output("t3_drop_load", b_load, 4'b0000);
    check_output("t3_drop_notes", b_vn, {6'd49, 6'd44, 6'd41, 6'd37});
    idle(1);
    check_output("t3_drop_end", b_drop, 1'b0);

    // Note coinciding with a beat; an expiring voice still counts as busy
    repeat (2) apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t4_pre_active", {a_act, b_act}, {4'b0111, 4'b0101});
    apply_stimulus(1'b1, 6'd20, 6'd3, 1'b1, 1'b0);
    check_output("t4_load", {a_load, b_load}, {4'b1000, 4'b0010});
    check_output("t4_active", {a_act, b_act}, {4'b1011, 4'b0011});
    check_output("t4_notes", {a_vn[23:18], b_vn[11:6]}, {6'd20, 6'd20});
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t4_beat1", {a_act, b_act}, {4'b1010, 4'b0010});
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t4_beat2", {a_act, b_act}, {4'b1000, 4'b0010});
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t4_beat3", {a_act, b_act}, 8'h00);
    apply_stimulus(1'b1, 6'd0, 6'd5, 1'b0, 1'b0);
    check_output("t4_rest_ignored", {a_act, b_act, a_load, b_load}, 16'h0);
    apply_stimulus(1'b1, 6'd10, 6'd0, 1'b0, 1'b0);
    check_output("t4_zero_dur_ignored", {a_act, b_act, a_load, b_load, a_drop, b_drop}, 18'h0);

    // Scaling and saturation boundaries
    apply_stimulus(1'b1, 6'd1, 6'd20, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd2, 6'd20, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd3, 6'd20, 1'b0, 1'b0);
    apply_stimulus(1'b1, 6'd4, 6'd20, 1'b0, 1'b0);
    check_output("t5_active", {a_act, b_act}, 8'hFF);
    set_vs(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000);
    request(16'sd30000, 16'sd32767);
    set_vs(-16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000);
    request(-16'sd30000, -16'sd32768);
    set_vs(16'sd1000, -16'sd3, 16'sd7, 16'sd2);
    request(16'sd251, 16'sd1006);
    set_vs(-16'sd1, 16'sd0, 16'sd0, 16'sd0);
    request(-16'sd1, -16'sd1);

    // Pause: countdown frozen, notes ignored, mixer outputs silence
    play = 1'b0;
    repeat (3) apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t6_pause_active", {a_act, b_act}, 8'hFF);
    apply_stimulus(1'b1, 6'd9, 6'd3, 1'b0, 1'b0);
    check_output("t6_pause_note", {a_load, b_load, a_drop, b_drop}, 10'h0);
    set_vs(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
    request(16'sd0, 16'sd0);
    play = 1'b1;
    repeat (19) apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t6_after_19", {a_act, b_act}, 8'hFF);
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    check_output("t6_after_20", {a_act, b_act}, 8'h00);

    // Reset in the middle of an accumulation
    apply_stimulus(1'b1, 6'd5, 6'd9, 1'b0, 1'b0);
    request(16'sd250, 16'sd1000);
    apply_stimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    idle(2);
    reset = 1'b1;
    #1;
    check_output("t6_rst_sample", {a_out, b_out}, 32'h0);
    check_output("t6_rst_state", {a_act, b_act, a_rdy, b_rdy}, 10'h0);
    check_output("t6_rst_notes", a_vn, 24'h0);
    idle(2);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (a_rdy || b_rdy) pulses++;
    end
    check_output("t6_no_ready", pulses, 0);
    check_output("t6_post_sample", {a_out, b_out}, 32'h0);

    for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    check_output("sb_drained", qa.size() + qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
